// File: rtl/hog_pkg.sv
// hog_pkg: shared constants, FSM state and output beat type for the HOG feature streamer.
package hog_pkg;
  localparam int CELL_NUM        = 289;
  localparam int BIN_NUM         = 18;
  localparam int FEAT_NUM        = CELL_NUM * BIN_NUM;
  localparam int BRAM_ADDR_W     = 13;
  localparam int TOTAL_BIT_WIDTH = 35;
  localparam int OUT_WIDTH       = 32;
  localparam int BIN_W           = $clog2(BIN_NUM);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [OUT_WIDTH-1:0] data;
    logic                 last_cell;
    logic                 last_frame;
  } beat_t;
endpackage

// File: rtl/hog_skid_fifo.sv
// hog_skid_fifo: synchronous show-ahead FIFO exposing its occupancy for upstream credit logic.
module hog_skid_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count,
  output logic          empty
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] count_q;
  assign rd_data = mem_q[rp_q];
  assign count = count_q;
  assign empty = count_q == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wp_q] <= wr_data;
        wp_q <= (wp_q == LAST) ? '0 : wp_q + 1'b1;
      end
      if (rd_en) rp_q <= (rp_q == LAST) ? '0 : rp_q + 1'b1;
      count_q <= count_q + CW'(wr_en) - CW'(rd_en);
    end
  end
endmodule

// File: rtl/hog_feature_stream.sv
// hog_feature_stream: sums four cell-histogram banks per bin and streams one feature word per bin.
// Define HOG_FEAT_SAT_EN to saturate oversized sums instead of truncating them.
module hog_feature_stream
  import hog_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       aclk,
  input  logic                       arest,
  input  logic                       histogram_done,
  output logic                       write_feature_done,
  output logic [BRAM_ADDR_W-1:0]     normal_addra_0,
  output logic [BRAM_ADDR_W-1:0]     normal_addra_1,
  output logic [BRAM_ADDR_W-1:0]     normal_addra_2,
  output logic [BRAM_ADDR_W-1:0]     normal_addra_3,
  input  logic [TOTAL_BIT_WIDTH-1:0] douta_0,
  input  logic [TOTAL_BIT_WIDTH-1:0] douta_1,
  input  logic [TOTAL_BIT_WIDTH-1:0] douta_2,
  input  logic [TOTAL_BIT_WIDTH-1:0] douta_3,
  output logic [OUT_WIDTH-1:0]       m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       m_tlast_cell,
  output logic                       m_tlast_frame,
  output logic                       busy
);
  localparam int OCW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;
  localparam int SW = TOTAL_BIT_WIDTH + 2;
`ifdef HOG_FEAT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam logic [BRAM_ADDR_W-1:0] ADDR_LAST = BRAM_ADDR_W'(FEAT_NUM - 1);
  localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(BIN_NUM - 1);
  state_t state_q, state_d;
  logic [BRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [READ_LATENCY-1:0] vld_q, lc_q, lf_q;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [OCW-1:0] occ;
  logic issue, wr, pop, empty;
  logic [SW-1:0] sum;
  beat_t wr_beat, rd_beat;
  // The address is combinational from the counter so the bank sees it in the first READ cycle.
  assign normal_addra_0 = addr_q;
  assign normal_addra_1 = addr_q;
  assign normal_addra_2 = addr_q;
  assign normal_addra_3 = addr_q;
  assign wr = vld_q[READ_LATENCY-1];
  assign sum = SW'(douta_0) + SW'(douta_1) + SW'(douta_2) + SW'(douta_3);
  assign wr_beat = '{
    data:       (SAT && |sum[SW-1:OUT_WIDTH]) ? '1 : sum[OUT_WIDTH-1:0],
    last_cell:  lc_q[READ_LATENCY-1],
    last_frame: lf_q[READ_LATENCY-1]
  };
  assign m_tvalid = !empty;
  assign pop = m_tvalid && m_tready;
  assign m_tdata = rd_beat.data;
  assign m_tlast_cell = rd_beat.last_cell;
  assign m_tlast_frame = rd_beat.last_frame;
  assign busy = (state_q == READ) || (state_q == DRAIN);
  assign write_feature_done = state_q == DONE;
  always_comb begin
    issue = (state_q == READ) && (CW'(occ) + inflight_q < CW'(FIFO_DEPTH));
    state_d = state_q;
    addr_d = addr_q;
    bin_d = bin_q;
    inflight_d = inflight_q + CW'(issue) - CW'(wr);
    if (issue) begin
      addr_d = addr_q + 1'b1;
      bin_d = (bin_q == BIN_LAST) ? '0 : bin_q + 1'b1;
    end
    case (state_q)
      IDLE: if (histogram_done) begin
        state_d = READ;
        addr_d = '0;
        bin_d = '0;
      end
      READ: if (issue && addr_q == ADDR_LAST) state_d = DRAIN;
      DRAIN: if (inflight_q == '0 && empty) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge aclk) begin
    if (arest) begin
      state_q <= IDLE;
      addr_q <= '0;
      bin_q <= '0;
      vld_q <= '0;
      lc_q <= '0;
      lf_q <= '0;
      inflight_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      bin_q <= bin_d;
      vld_q <= READ_LATENCY'({vld_q, issue});
      lc_q <= READ_LATENCY'({lc_q, bin_q == BIN_LAST});
      lf_q <= READ_LATENCY'({lf_q, addr_q == ADDR_LAST});
      inflight_q <= inflight_d;
    end
  end
  hog_skid_fifo #(.W($bits(beat_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(aclk),
    .rst(arest),
    .wr_en(wr),
    .wr_data(wr_beat),
    .rd_en(pop),
    .rd_data(rd_beat),
    .count(occ),
    .empty(empty)
  );
endmodule

// File: tb/tb_hog_feature_stream.sv
// tb_hog_feature_stream: directed scenarios against a two-cycle bank model; beats are recorded by a monitor.
module tb_hog_feature_stream;
  import hog_pkg::*;
  logic aclk = 1'b0, arest = 1'b1, histogram_done = 1'b0, m_tready = 1'b0;
  logic write_feature_done, m_tvalid, m_tlast_cell, m_tlast_frame, busy;
  logic [BRAM_ADDR_W-1:0] addra [4];
  logic [BRAM_ADDR_W-1:0] a1 [4];
  logic [TOTAL_BIT_WIDTH-1:0] douta [4];
  logic [OUT_WIDTH-1:0] m_tdata;
  bit all_ones = 1'b0;
  int compared = 0, mismatched = 0, cyc = 0;
  int nbeats, ndone, done_beats, first_cyc, last_cyc, hd_cyc, stall_bad, occ_max;
  logic [33:0] rec [FEAT_NUM];
  logic [33:0] prev_beat;
  bit prev_stall = 1'b0;
  bit to;
`ifdef HOG_FEAT_SAT_EN
  localparam logic [31:0] SATV = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] SATV = 32'hFFFF_FFFC;
`endif

  hog_feature_stream dut (
    .aclk(aclk), .arest(arest), .histogram_done(histogram_done),
    .write_feature_done(write_feature_done),
    .normal_addra_0(addra[0]), .normal_addra_1(addra[1]),
    .normal_addra_2(addra[2]), .normal_addra_3(addra[3]),
    .douta_0(douta[0]), .douta_1(douta[1]), .douta_2(douta[2]), .douta_3(douta[3]),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast_cell(m_tlast_cell), .m_tlast_frame(m_tlast_frame), .busy(busy)
  );

  always #5 aclk = ~aclk;

  // Bank i holds addr+i (or all ones); address register plus output register gives two cycles.
  always @(posedge aclk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 4; i++) begin
      a1[i] <= addra[i];
      douta[i] <= all_ones ? '1 : TOTAL_BIT_WIDTH'(a1[i]) + TOTAL_BIT_WIDTH'(i);
    end
  end

  always @(negedge aclk) begin
    if (arest) prev_stall = 1'b0;
    else begin
      if (prev_stall && (!m_tvalid || {m_tdata, m_tlast_cell, m_tlast_frame} !== prev_beat)) stall_bad++;
      if (m_tvalid && first_cyc < 0) first_cyc = cyc;
      if (m_tvalid && m_tready) begin
        if (nbeats < FEAT_NUM) rec[nbeats] = {m_tdata, m_tlast_cell, m_tlast_frame};
        nbeats++;
        last_cyc = cyc;
      end
      if (write_feature_done) begin
        ndone++;
        done_beats = nbeats;
      end
      if (int'(dut.u_fifo.count_q) > occ_max) occ_max = int'(dut.u_fifo.count_q);
      prev_stall = m_tvalid && !m_tready;
      prev_beat = {m_tdata, m_tlast_cell, m_tlast_frame};
    end
  end

  function automatic logic [33:0] exp_beat(input int k, input bit sat);
    logic [31:0] d;
    d = sat ? SATV : 32'(4 * k + 6);
    return {d, (k % BIN_NUM) == BIN_NUM - 1, k == FEAT_NUM - 1};
  endfunction

  task automatic start_frame();
    nbeats = 0; ndone = 0; done_beats = -1; first_cyc = -1; last_cyc = -1; stall_bad = 0; occ_max = 0;
    for (int k = 0; k < FEAT_NUM; k++) rec[k] = '0;
    histogram_done = 1'b1;
    hd_cyc = cyc;
    @(posedge aclk);
    #1 histogram_done = 1'b0;
  endtask

  task automatic drive_until(input int pct, input int beats, input int max_cyc, output bit timeout);
    int n = 0;
    timeout = 1'b0;
    while (ndone == 0 && nbeats < beats) begin
      @(posedge aclk);
      #1 m_tready = ($urandom_range(99) < pct);
      n++;
      if (n > max_cyc) begin
        timeout = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge aclk);
    #1;
    compared++; if ({m_tvalid, busy, write_feature_done, m_tlast_cell, m_tlast_frame} !== 5'b0) begin
      mismatched++; $display("FAIL reset_flags: got %b want 00000", {m_tvalid, busy, write_feature_done, m_tlast_cell, m_tlast_frame});
    end
    compared++; if (m_tdata !== 32'h0) begin mismatched++; $display("FAIL reset_tdata: got %h want 0", m_tdata); end
    compared++; if ({addra[0], addra[1], addra[2], addra[3]} !== 52'h0) begin
      mismatched++; $display("FAIL reset_addr: got %h %h %h %h want 0", addra[0], addra[1], addra[2], addra[3]);
    end
    arest = 1'b0;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_ramp();
    all_ones = 1'b0;
    m_tready = 1'b1;
    start_frame();
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL ramp_busy: got %b want 1", busy); end
    drive_until(100, 1 << 30, 6000, to);
    compared++; if (to) begin mismatched++; $display("FAIL ramp_timeout: got timeout want done"); end
    compared++; if (first_cyc - hd_cyc !== 4) begin mismatched++; $display("FAIL ramp_latency: got %0d want 4", first_cyc - hd_cyc); end
    compared++; if (last_cyc - first_cyc !== FEAT_NUM - 1) begin mismatched++; $display("FAIL ramp_rate: got %0d want %0d", last_cyc - first_cyc, FEAT_NUM - 1); end
    compared++; if (nbeats !== FEAT_NUM) begin mismatched++; $display("FAIL ramp_count: got %0d want %0d", nbeats, FEAT_NUM); end
    compared++; if (ndone !== 1 || done_beats !== FEAT_NUM) begin mismatched++; $display("FAIL ramp_done: got %0d pulses after %0d beats want 1 after %0d", ndone, done_beats, FEAT_NUM); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL ramp_idle_busy: got %b want 0", busy); end
    for (int k = 0; k < FEAT_NUM; k++) begin
      compared++; if (rec[k] !== exp_beat(k, 1'b0)) begin mismatched++; $display("FAIL ramp_beat %0d: got %h want %h", k, rec[k], exp_beat(k, 1'b0)); end
    end
  endtask

  task automatic test_saturate();
    all_ones = 1'b1;
    m_tready = 1'b1;
    start_frame();
    drive_until(100, 1 << 30, 6000, to);
    compared++; if (to || ndone !== 1) begin mismatched++; $display("FAIL sat_done: got %0d pulses (timeout %b) want 1", ndone, to); end
    for (int k = 0; k < FEAT_NUM; k++) begin
      compared++; if (rec[k] !== exp_beat(k, 1'b1)) begin mismatched++; $display("FAIL sat_beat %0d: got %h want %h", k, rec[k], exp_beat(k, 1'b1)); end
    end
    all_ones = 1'b0;
  endtask

  task automatic test_backpressure();
    m_tready = 1'b0;
    start_frame();
    drive_until(30, 1 << 30, 30000, to);
    compared++; if (to || ndone !== 1) begin mismatched++; $display("FAIL bp_done: got %0d pulses (timeout %b) want 1", ndone, to); end
    compared++; if (nbeats !== FEAT_NUM) begin mismatched++; $display("FAIL bp_count: got %0d want %0d", nbeats, FEAT_NUM); end
    compared++; if (stall_bad !== 0) begin mismatched++; $display("FAIL bp_stable: got %0d changes while stalled want 0", stall_bad); end
    compared++; if (occ_max > 4) begin mismatched++; $display("FAIL bp_occupancy: got %0d want <= 4", occ_max); end
    for (int k = 0; k < FEAT_NUM; k++) begin
      compared++; if (rec[k] !== exp_beat(k, 1'b0)) begin mismatched++; $display("FAIL bp_beat %0d: got %h want %h", k, rec[k], exp_beat(k, 1'b0)); end
    end
  endtask

  task automatic test_retrigger();
    m_tready = 1'b1;
    start_frame();
    drive_until(100, 100, 2000, to);
    compared++; if (to) begin mismatched++; $display("FAIL retrig_reach: got timeout want beat 100"); end
    histogram_done = 1'b1;
    @(posedge aclk);
    #1 histogram_done = 1'b0;
    drive_until(100, 1 << 30, 6000, to);
    compared++; if (to || ndone !== 1) begin mismatched++; $display("FAIL retrig_done: got %0d pulses (timeout %b) want 1", ndone, to); end
    compared++; if (nbeats !== FEAT_NUM) begin mismatched++; $display("FAIL retrig_count: got %0d want %0d", nbeats, FEAT_NUM); end
    for (int k = 0; k < FEAT_NUM; k++) begin
      compared++; if (rec[k] !== exp_beat(k, 1'b0)) begin mismatched++; $display("FAIL retrig_beat %0d: got %h want %h", k, rec[k], exp_beat(k, 1'b0)); end
    end
  endtask

  task automatic test_reset_mid();
    m_tready = 1'b1;
    start_frame();
    drive_until(100, 2000, 3000, to);
    compared++; if (to) begin mismatched++; $display("FAIL rstmid_reach: got timeout want beat 2000"); end
    arest = 1'b1;
    @(posedge aclk);
    #1 arest = 1'b0;
    compared++; if ({m_tvalid, busy} !== 2'b00) begin mismatched++; $display("FAIL rstmid_flush: got valid=%b busy=%b want 0 0", m_tvalid, busy); end
    drive_until(100, 1 << 30, 20, to);
    compared++; if (ndone !== 0) begin mismatched++; $display("FAIL rstmid_nodone: got %0d pulses want 0", ndone); end
    start_frame();
    drive_until(100, 1 << 30, 6000, to);
    compared++; if (rec[0] !== {32'd6, 2'b00}) begin mismatched++; $display("FAIL rstmid_first: got %h want %h", rec[0], {32'd6, 2'b00}); end
    compared++; if (to || ndone !== 1 || nbeats !== FEAT_NUM) begin
      mismatched++; $display("FAIL rstmid_frame: got %0d beats %0d pulses want %0d beats 1 pulse", nbeats, ndone, FEAT_NUM);
    end
    for (int k = 0; k < FEAT_NUM; k++) begin
      compared++; if (rec[k] !== exp_beat(k, 1'b0)) begin mismatched++; $display("FAIL rstmid_beat %0d: got %h want %h", k, rec[k], exp_beat(k, 1'b0)); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_saturate();
    test_backpressure();
    test_retrigger();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
